// File: rtl/lemmings_pkg.sv
// rtl/lemmings_pkg.sv - shared encodings and defaults for the lemmings FSM and its world model
package lemmings_pkg;

  typedef enum logic [1:0] {
    ST_L   = 2'd0,
    ST_R   = 2'd1,
    ST_F_L = 2'd2,
    ST_F_R = 2'd3
  } lem_state_t;

  localparam logic LVL_TOP = 1'b0;
  localparam logic LVL_PIT = 1'b1;

  localparam int DEF_PIT_DEFAULT     = 4;
  localparam int SPLAT_LIMIT_DEFAULT = 20;

endpackage

// File: rtl/lemmings_terrain_map.sv
// rtl/lemmings_terrain_map.sv - per-column floor/wall registers with a config write port
module lemmings_terrain_map
  import lemmings_pkg::*;
#(
  parameter int COLS = 16,
  parameter int XW   = 4
) (
  input  logic          clk,
  input  logic          areset,
  input  logic          cfg_we,
  input  logic [XW-1:0] cfg_col,
  input  logic          cfg_floor,
  input  logic          cfg_wall,
  input  logic [XW-1:0] pos_x,
  output logic          floor_here,
  output logic          wall_left,
  output logic          wall_right
);

  logic [COLS-1:0] floor_q;
  logic [COLS-1:0] wall_q;

  // Columns past COLS exist only when COLS is not a power of two; writes there are dropped.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      floor_q <= '1;
      wall_q  <= '0;
    end else if (cfg_we && (32'(cfg_col) < COLS)) begin
      floor_q[cfg_col] <= cfg_floor;
      wall_q[cfg_col]  <= cfg_wall;
    end
  end

  // Neighbour lookups are guarded at the edges so the index never wraps.
  always_comb begin
    floor_here = floor_q[pos_x];
    wall_left  = 1'b0;
    wall_right = 1'b0;
    if (pos_x != '0)
      wall_left = wall_q[pos_x - 1'b1];
    if (32'(pos_x) < COLS - 1)
      wall_right = wall_q[pos_x + 1'b1];
  end

endmodule

// File: rtl/lemmings_world.sv
// rtl/lemmings_world.sv - lemming position, level, fall length and splat tracking on a 1-D terrain
module lemmings_world
  import lemmings_pkg::*;
#(
  parameter int COLS        = 16,
  parameter int XW          = 4,
  parameter int FALL_W      = 5,
  parameter int START_X     = 8,
  parameter int DEF_PIT     = DEF_PIT_DEFAULT,
  parameter int SPLAT_LIMIT = SPLAT_LIMIT_DEFAULT
) (
  input  logic              clk,
  input  logic              areset,
  input  logic              cfg_we,
  input  logic [XW-1:0]     cfg_col,
  input  logic              cfg_floor,
  input  logic              cfg_wall,
  input  logic              cfg_pit_we,
  input  logic [FALL_W-1:0] cfg_pit,
  input  logic              walk_left,
  input  logic              walk_right,
  input  logic              aaah,
  output logic              ground,
  output logic              bump_left,
  output logic              bump_right,
  output logic [XW-1:0]     pos_x,
  output logic              level,
  output logic [FALL_W-1:0] fall_cnt,
  output logic              splat
);

  logic [XW-1:0]     pos_q;
  logic              level_q;
  logic [FALL_W-1:0] fall_q;
  logic              splat_q;
  logic [FALL_W-1:0] pit_q;
  logic              aaah_q;

  logic floor_here, wall_left, wall_right;

  lemmings_terrain_map #(
    .COLS(COLS),
    .XW  (XW)
  ) u_map (
    .clk       (clk),
    .areset    (areset),
    .cfg_we    (cfg_we),
    .cfg_col   (cfg_col),
    .cfg_floor (cfg_floor),
    .cfg_wall  (cfg_wall),
    .pos_x     (pos_q),
    .floor_here(floor_here),
    .wall_left (wall_left),
    .wall_right(wall_right)
  );

  // Outputs depend only on registered state so the FSM loop stays cut.
  assign ground     = (level_q == LVL_PIT) ? 1'b1 : floor_here;
  assign bump_left  = (pos_q == '0) | ((level_q == LVL_TOP) & wall_left);
  assign bump_right = (32'(pos_q) == COLS - 1) | ((level_q == LVL_TOP) & wall_right);
  assign pos_x      = pos_q;
  assign level      = level_q;
  assign fall_cnt   = fall_q;
  assign splat      = splat_q;

  logic              move_l, move_r;
  logic              falling, landing, hard_landing;
  logic [FALL_W:0]   fall_len;
  logic [FALL_W-1:0] fall_sat;
  logic [FALL_W-1:0] eff_pit;

  assign move_l = !aaah && walk_left && !walk_right && !bump_left;
  assign move_r = !aaah && walk_right && !walk_left && !bump_right;

  // A fall restarts its count on the cycle aaah rises; one extra bit keeps the raw length.
  assign fall_len     = (aaah_q ? {1'b0, fall_q} : '0) + (FALL_W+1)'(1);
  assign fall_sat     = fall_len[FALL_W] ? '1 : fall_len[FALL_W-1:0];
  assign eff_pit      = (pit_q == '0) ? FALL_W'(1) : pit_q;
  assign falling      = aaah && (level_q == LVL_TOP);
  assign landing      = falling && (fall_len >= {1'b0, eff_pit});
  assign hard_landing = landing && (32'(fall_len) > SPLAT_LIMIT);

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      pos_q   <= XW'(START_X);
      level_q <= LVL_TOP;
      fall_q  <= '0;
      splat_q <= 1'b0;
      pit_q   <= FALL_W'(DEF_PIT);
      aaah_q  <= 1'b0;
    end else begin
      aaah_q <= aaah;
      if (move_l)
        pos_q <= pos_q - 1'b1;
      else if (move_r)
        pos_q <= pos_q + 1'b1;
      if (falling)
        fall_q <= fall_sat;
      if (landing)
        level_q <= LVL_PIT;
      if (hard_landing)
        splat_q <= 1'b1;
      if (cfg_pit_we)
        pit_q <= cfg_pit;
    end
  end

endmodule

// File: tb/tb_lemmings_world.sv
// tb/tb_lemmings_world.sv - randomized and directed checks of lemmings_world against a behavioural model
module tb_lemmings_world;

  logic       clk = 1'b0;
  logic       areset;
  logic       cfg_we, cfg_floor, cfg_wall, cfg_pit_we;
  logic [3:0] cfg_col;
  logic [4:0] cfg_pit;
  logic       walk_left, walk_right, aaah;
  logic       ground, bump_left, bump_right, level, splat;
  logic [3:0] pos_x;
  logic [4:0] fall_cnt;

  lemmings_world dut (
    .clk       (clk),
    .areset    (areset),
    .cfg_we    (cfg_we),
    .cfg_col   (cfg_col),
    .cfg_floor (cfg_floor),
    .cfg_wall  (cfg_wall),
    .cfg_pit_we(cfg_pit_we),
    .cfg_pit   (cfg_pit),
    .walk_left (walk_left),
    .walk_right(walk_right),
    .aaah      (aaah),
    .ground    (ground),
    .bump_left (bump_left),
    .bump_right(bump_right),
    .pos_x     (pos_x),
    .level     (level),
    .fall_cnt  (fall_cnt),
    .splat     (splat)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  bit m_floor[16];
  bit m_wall[16];
  int m_pit, m_px, m_lv, m_fc, m_sp, m_prev;

  function automatic int m_ground();
    return (m_lv != 0) ? 1 : int'(m_floor[m_px]);
  endfunction

  function automatic int m_bl();
    if (m_px == 0) return 1;
    return (m_lv == 0 && m_wall[m_px-1]) ? 1 : 0;
  endfunction

  function automatic int m_br();
    if (m_px == 15) return 1;
    return (m_lv == 0 && m_wall[m_px+1]) ? 1 : 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_floor[i] = 1'b1;
      m_wall[i]  = 1'b0;
    end
    m_pit = 4; m_px = 8; m_lv = 0; m_fc = 0; m_sp = 0; m_prev = 0;
  endtask

  task automatic model_step();
    int len, eff, bl, br;
    bl = m_bl();
    br = m_br();
    if (!aaah) begin
      if (walk_left && !walk_right && bl == 0) m_px = m_px - 1;
      else if (walk_right && !walk_left && br == 0) m_px = m_px + 1;
    end else if (m_lv == 0) begin
      len  = (m_prev != 0) ? m_fc + 1 : 1;
      m_fc = (len > 31) ? 31 : len;
      eff  = (m_pit == 0) ? 1 : m_pit;
      if (len >= eff) begin
        m_lv = 1;
        if (len > 20) m_sp = 1;
      end
    end
    m_prev = aaah;
    if (cfg_we) begin
      m_floor[cfg_col] = cfg_floor;
      m_wall[cfg_col]  = cfg_wall;
    end
    if (cfg_pit_we) m_pit = cfg_pit;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("ground", ground, m_ground());
      check("bump_left", bump_left, m_bl());
      check("bump_right", bump_right, m_br());
      check("pos_x", pos_x, m_px);
      check("level", level, m_lv);
      check("fall_cnt", fall_cnt, m_fc);
      check("splat", splat, m_sp);
    end
  end

  task automatic cycle(input bit wl, input bit wr, input bit aa,
                       input bit cw, input int col, input bit fl, input bit wa,
                       input bit pw, input int pit);
    walk_left  = wl;
    walk_right = wr;
    aaah       = aa;
    cfg_we     = cw;
    cfg_col    = col[3:0];
    cfg_floor  = fl;
    cfg_wall   = wa;
    cfg_pit_we = pw;
    cfg_pit    = pit[4:0];
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input bit wl, input bit wr, input bit aa);
    cycle(wl, wr, aa, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0);
  endtask

  // Reset lands mid-cycle; outputs must reach reset values before the next edge.
  task automatic do_reset();
    #2;
    areset = 1'b1;
    model_reset();
    #1;
    check("rst_pos_x", pos_x, 8);
    check("rst_ground", ground, 1);
    check("rst_level", level, 0);
    check("rst_fall_cnt", fall_cnt, 0);
    check("rst_splat", splat, 0);
    check("rst_bump_left", bump_left, 0);
    check("rst_bump_right", bump_right, 0);
    @(posedge clk);
    #1;
    areset = 1'b0;
  endtask

  initial begin
    areset = 1'b1;
    walk_left = 0; walk_right = 0; aaah = 0;
    cfg_we = 0; cfg_col = 0; cfg_floor = 0; cfg_wall = 0; cfg_pit_we = 0; cfg_pit = 0;
    model_reset();
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    areset = 1'b0;

    // Walk to the right edge and stay there.
    for (int i = 0; i < 7; i++) idle(1'b0, 1'b1, 1'b0);
    check("t1_pos_x", pos_x, 15);
    check("t1_bump_right", bump_right, 1);
    idle(1'b0, 1'b1, 1'b0);
    check("t1_pos_hold", pos_x, 15);

    // Wall at column 5 stops a left walk at 6.
    do_reset();
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 5, 1'b1, 1'b1, 1'b0, 0);
    idle(1'b1, 1'b0, 1'b0);
    idle(1'b1, 1'b0, 1'b0);
    check("t2_pos_x", pos_x, 6);
    check("t2_bump_left", bump_left, 1);
    idle(1'b0, 1'b1, 1'b0);
    check("t2_away_bump", bump_left, 0);

    // Hole at 9, default pit depth of 4.
    do_reset();
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 9, 1'b0, 1'b0, 1'b0, 0);
    check("t3_pos_x", pos_x, 9);
    check("t3_ground", ground, 0);
    for (int i = 0; i < 3; i++) idle(1'b0, 1'b0, 1'b1);
    check("t3_level_mid", level, 0);
    idle(1'b0, 1'b0, 1'b1);
    check("t3_level", level, 1);
    check("t3_ground_land", ground, 1);
    check("t3_fall_cnt", fall_cnt, 4);
    check("t3_splat", splat, 0);

    // Deep pit of 22 splats.
    do_reset();
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 9, 1'b0, 1'b0, 1'b1, 22);
    for (int i = 0; i < 21; i++) idle(1'b0, 1'b0, 1'b1);
    check("t4_level_mid", level, 0);
    check("t4_fall_mid", fall_cnt, 21);
    idle(1'b0, 1'b0, 1'b1);
    check("t4_level", level, 1);
    check("t4_fall_cnt", fall_cnt, 22);
    check("t4_splat", splat, 1);
    for (int i = 0; i < 3; i++) idle(1'b1, 1'b0, 1'b0);
    check("t4_splat_sticky", splat, 1);
    check("t4_pos_x", pos_x, 6);

    // Pit depth 0 lands at once; level 1 ignores map walls.
    do_reset();
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 8, 1'b0, 1'b0, 1'b1, 0);
    for (int c = 2; c < 8; c++) cycle(1'b0, 1'b0, 1'b0, 1'b1, c, 1'b1, 1'b1, 1'b0, 0);
    idle(1'b0, 1'b0, 1'b1);
    check("t5_level", level, 1);
    check("t5_fall_cnt", fall_cnt, 1);
    for (int i = 0; i < 7; i++) idle(1'b1, 1'b0, 1'b0);
    check("t5_pos_1", pos_x, 1);
    check("t5_bump_1", bump_left, 0);
    idle(1'b1, 1'b0, 1'b0);
    check("t5_pos_0", pos_x, 0);
    check("t5_bump_0", bump_left, 1);

    // Reset during a fall.
    do_reset();
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 8, 1'b0, 1'b0, 1'b0, 0);
    idle(1'b0, 1'b0, 1'b1);
    idle(1'b0, 1'b0, 1'b1);
    check("t6_fall_cnt", fall_cnt, 2);
    check("t6_ground", ground, 0);
    do_reset();

    // Randomized traffic with an FSM-like aaah pattern.
    for (int n = 0; n < 4000; n++) begin
      bit aa;
      if ($urandom_range(0, 69) == 0) begin
        do_reset();
      end else begin
        if (m_ground() == 0) aa = ($urandom_range(0, 9) != 0);
        else aa = ($urandom_range(0, 19) == 0);
        cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), aa,
              ($urandom_range(0, 4) == 0), int'($urandom_range(0, 15)),
              ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 14) == 0), int'($urandom_range(0, 31)));
      end
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
